// File: rtl/comb_eval_pkg.sv
// Shared types and widths for the combinational-core evaluation sequencer.
package comb_eval_pkg;

  localparam int CORE_IN_W  = 14;
  localparam int CORE_OUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } eval_state_t;

endpackage

// File: rtl/comb_eval_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/comb_eval_arbiter.sv
// Shares one combinational netlist core between two requesters: arbitrate, drive, settle,
// capture the core outputs and return them tagged with the requester id.
module comb_eval_arbiter
  import comb_eval_pkg::*;
#(
  parameter int IN_W   = CORE_IN_W,
  parameter int OUT_W  = CORE_OUT_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_vec,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_vec,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [OUT_W-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      done0_cnt,
  output logic [15:0]      done1_cnt
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_settle_chk
    $fatal(1, "comb_eval_arbiter: SETTLE must be within 1..255");
  end

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  eval_state_t      state_q;
  logic [7:0]       cnt_q;
  logic             last_grant_q;
  logic [IN_W-1:0]  core_in_q;
  logic [OUT_W-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic             busy_q;
  logic [15:0]      done0_q;
  logic [15:0]      done1_q;
  logic [1:0]       grant;
  logic             in_idle;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = in_idle & grant[0];
  assign req1_ready = in_idle & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      core_in_q    <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      done0_q      <= 16'd0;
      done1_q      <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            core_in_q    <= grant[1] ? req1_vec : req0_vec;
            rsp_id_q     <= grant[1];
            last_grant_q <= grant[1];
            cnt_q        <= SETTLE_LD;
            state_q      <= ST_SETTLE;
            busy_q       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q - 8'd1;
          // cnt_q == 1 marks edge T+SETTLE after acceptance
          if (cnt_q == 8'd1) begin
            rsp_data_q <= core_out;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (rsp_id_q) done1_q <= done1_q + 16'd1;
            else          done0_q <= done0_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_in   = core_in_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign done0_cnt = done0_q;
  assign done1_cnt = done1_q;

endmodule

// File: tb/tb_comb_eval_arbiter.sv
// Self-checking bench for comb_eval_arbiter: vector table, random traffic against a
// round-robin reference model, and hand sequences for stall, reset abort and wrap.
module tb_comb_eval_arbiter;

  localparam int IN_W     = 14;
  localparam int OUT_W    = 8;
  localparam int SETTLE   = 2;
  localparam int SETTLE_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [IN_W-1:0]  req0_vec = '0, req1_vec = '0;
  logic [IN_W-1:0]  core_in;
  logic [OUT_W-1:0] core_out;
  logic [OUT_W-1:0] core_q = '0;
  logic             rsp_valid, rsp_id, busy;
  logic             rsp_ready = 1'b0;
  logic [OUT_W-1:0] rsp_data;
  logic [15:0]      done0_cnt, done1_cnt;

  // core stand-in with one register of delay
  always @(posedge clk) core_q <= core_in[7:0] ^ 8'hA5;
  assign core_out = core_q;

  comb_eval_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vec(req0_vec),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vec(req1_vec),
    .core_in(core_in), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  // second instance, SETTLE=1 with a purely combinational core, for throughput
  logic             req0_valid_b = 1'b0;
  logic             req1_valid_b = 1'b0;
  logic             req0_ready_b, req1_ready_b;
  logic [IN_W-1:0]  req0_vec_b = 14'h1234;
  logic [IN_W-1:0]  req1_vec_b = '0;
  logic [IN_W-1:0]  core_in_b;
  logic [OUT_W-1:0] core_out_b;
  logic             rsp_valid_b, rsp_id_b, busy_b;
  logic             rsp_ready_b = 1'b1;
  logic [OUT_W-1:0] rsp_data_b;
  logic [15:0]      done0_cnt_b, done1_cnt_b;

  assign core_out_b = core_in_b[7:0] ^ 8'hA5;

  comb_eval_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_vec(req0_vec_b),
    .req1_valid(req1_valid_b), .req1_ready(req1_ready_b), .req1_vec(req1_vec_b),
    .core_in(core_in_b), .core_out(core_out_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b),
    .busy(busy_b), .done0_cnt(done0_cnt_b), .done1_cnt(done1_cnt_b)
  );

  int errs = 0;
  int checks = 0;

  // reference model state: who won last, and completions per requester
  logic        mdl_last;
  logic [15:0] mdl_cnt [2];

  typedef struct {
    logic            v0;
    logic [IN_W-1:0] a;
    logic            v1;
    logic [IN_W-1:0] b;
    int              stall;
    logic            exp_id;
    logic [7:0]      exp_data;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_last = 1'b1;
    mdl_cnt[0] = 16'd0;
    mdl_cnt[1] = 16'd0;
  endtask

  // One transaction; the losing requester keeps its valid high throughout.
  task automatic txn(input logic v0, input logic [IN_W-1:0] a, input logic v1,
                     input logic [IN_W-1:0] b, input int stall,
                     input logic exp_id, input logic [7:0] exp_data);
    logic [IN_W-1:0] vec;
    int lat;
    vec = exp_id ? b : a;
    req0_valid = v0;
    req0_vec   = a;
    req1_valid = v1;
    req1_vec   = b;
    rsp_ready  = (stall == 0);
    #1;
    chk("grant", 32'({req1_ready, req0_ready}), exp_id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    mdl_last = exp_id;
    if (exp_id) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
    chk("core_in", 32'(core_in), 32'(vec));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      chk("ready_in_settle", 32'({req1_ready, req0_ready}), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(SETTLE));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(exp_data));
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_ready", 32'({req1_ready, req0_ready}), 32'd0);
      chk("stall_core_in", 32'(core_in), 32'(vec));
    end
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("resp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    mdl_cnt[exp_id] = mdl_cnt[exp_id] + 16'd1;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("done0_cnt", 32'(done0_cnt), 32'(mdl_cnt[0]));
    chk("done1_cnt", 32'(done1_cnt), 32'(mdl_cnt[1]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, hits, start_wait;
    logic [1:0] v;
    logic [IN_W-1:0] ra, rb;
    logic g;

    tbl[0]  = '{1'b1, 14'h0001, 1'b1, 14'h0002, 0,  1'b0, 8'hA4};
    tbl[1]  = '{1'b1, 14'h0001, 1'b1, 14'h0002, 0,  1'b1, 8'hA7};
    tbl[2]  = '{1'b1, 14'h0010, 1'b1, 14'h0020, 0,  1'b0, 8'hB5};
    tbl[3]  = '{1'b1, 14'h0010, 1'b1, 14'h0020, 1,  1'b1, 8'h85};
    tbl[4]  = '{1'b0, 14'h0000, 1'b1, 14'h3FFF, 0,  1'b1, 8'h5A};
    tbl[5]  = '{1'b0, 14'h0000, 1'b1, 14'h0100, 10, 1'b1, 8'hA5};
    tbl[6]  = '{1'b1, 14'h0123, 1'b0, 14'h0000, 0,  1'b0, 8'h86};
    tbl[7]  = '{1'b1, 14'h00FF, 1'b0, 14'h0000, 3,  1'b0, 8'h5A};
    tbl[8]  = '{1'b1, 14'h2055, 1'b0, 14'h0000, 0,  1'b0, 8'hF0};
    tbl[9]  = '{1'b1, 14'h0AAA, 1'b1, 14'h1555, 2,  1'b1, 8'hF0};
    tbl[10] = '{1'b1, 14'h0000, 1'b0, 14'h0000, 0,  1'b0, 8'hA5};

    // reset values, sampled while reset is still asserted
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_in", 32'(core_in), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done0_cnt), 32'd0);
    chk("rst_done1", 32'(done1_cnt), 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    do_reset();

    txn(1'b1, 14'h0123, 1'b0, 14'h0000, 0, 1'b0, 8'h86);
    chk("single_done0", 32'(done0_cnt), 32'd1);

    do_reset();
    for (int i = 0; i < 11; i++)
      txn(tbl[i].v0, tbl[i].a, tbl[i].v1, tbl[i].b, tbl[i].stall, tbl[i].exp_id, tbl[i].exp_data);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      ra = 14'($urandom);
      rb = 14'($urandom);
      g  = (v == 2'b11) ? ~mdl_last : v[1];
      txn(v[0], ra, v[1], rb, int'($urandom_range(0, 3)), g, (g ? rb[7:0] : ra[7:0]) ^ 8'hA5);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // throughput on the SETTLE=1 instance with rsp_ready tied high
    req0_valid_b = 1'b1;
    start_wait = 0;
    @(posedge clk);
    #1;
    while (!rsp_valid_b && start_wait < 20) begin
      @(posedge clk);
      #1;
      start_wait++;
    end
    chk("thru_first_valid", 32'(rsp_valid_b), 32'd1);
    chk("thru_data", 32'(rsp_data_b), 32'h91);
    bad = 0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid_b !== ((i % (SETTLE_B + 2)) == 0)) bad++;
      if (rsp_valid_b) hits++;
      @(posedge clk);
      #1;
    end
    chk("thru_pattern_errs", 32'(bad), 32'd0);
    chk("thru_hits", 32'(hits), 32'd10);
    req0_valid_b = 1'b0;

    // reset one cycle after acceptance aborts the transaction
    do_reset();
    req0_valid = 1'b1;
    req0_vec = 14'h0077;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("abort_accepted", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_core_in", 32'(core_in), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("abort_no_rsp", 32'(bad), 32'd0);
    chk("abort_done0", 32'(done0_cnt), 32'd0);
    chk("abort_done1", 32'(done1_cnt), 32'd0);

    // counter wrap
    force dut.done0_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.done0_q;
    chk("wrap_preload", 32'(done0_cnt), 32'hFFFF);
    mdl_last = 1'b1;
    mdl_cnt[0] = 16'hFFFF;
    mdl_cnt[1] = 16'd0;
    txn(1'b1, 14'h0042, 1'b0, 14'h0000, 0, 1'b0, 8'hE7);
    chk("wrap_zero", 32'(done0_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
